// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// Owner encoding doubles as the bit index into the two-bit request/grant vectors.
package mem_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } owner_e;

    function automatic owner_e other_owner(input owner_e o);
        owner_e r;
        if (o == OWN_CPU) begin
            r = OWN_EXT;
        end else begin
            r = OWN_CPU;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the side
// that did not own the previous access. Purely combinational.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last_owner,
    output logic [1:0] grant,
    output owner_e     winner
);

    // Pick the winner from the live request pair and the previous owner
    always_comb begin
        grant  = 2'b00;
        winner = last_owner;
        case (req)
            2'b01: begin
                grant  = 2'b01;
                winner = OWN_CPU;
            end
            2'b10: begin
                grant  = 2'b10;
                winner = OWN_EXT;
            end
            2'b11: begin
                winner = other_owner(last_owner);
                if (other_owner(last_owner) == OWN_CPU) begin
                    grant = 2'b01;
                end else begin
                    grant = 2'b10;
                end
            end
            default: begin
                grant  = 2'b00;
                winner = last_owner;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one unified memory between the CPU control unit and the EXT port
// (loader / DMA): one access in flight, round-robin on ties, fixed read latency.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // RD_LAT is limited to 1..7 so the wait count fits in CNT_W bits.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    arb_state_e        state_q,      state_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    owner_e            last_owner_q, last_owner_d;
    owner_e            rd_owner_q,   rd_owner_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              ext_rvalid_q, ext_rvalid_d;
    logic [DATA_W-1:0] cpu_rdata_q,  cpu_rdata_d;
    logic [DATA_W-1:0] ext_rdata_q,  ext_rdata_d;

    logic [1:0]        pick_req_s;
    logic [1:0]        pick_grant_s;
    owner_e            pick_winner_s;

    // Requests are masked while Reset is asserted so nothing is granted then
    always_comb begin
        pick_req_s = {ext_req, cpu_req} & {2{Reset}};
    end

    rr_pick2 u_pick (
        .req        (pick_req_s),
        .last_owner (last_owner_q),
        .grant      (pick_grant_s),
        .winner     (pick_winner_s)
    );

    // Next-state, memory strobe and read-return logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;
        rd_owner_d   = rd_owner_q;
        cpu_rvalid_d = 1'b0;
        ext_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        ext_rdata_d  = ext_rdata_q;
        cpu_gnt      = 1'b0;
        ext_gnt      = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = {ADDR_W{1'b0}};
        mem_wdata    = {DATA_W{1'b0}};
        case (state_q)
            IDLE: begin
                if (pick_grant_s != 2'b00) begin
                    cpu_gnt = pick_grant_s[0];
                    ext_gnt = pick_grant_s[1];
                    mem_en  = 1'b1;
                    if (pick_winner_s == OWN_CPU) begin
                        mem_we    = cpu_we;
                        mem_addr  = cpu_addr;
                        mem_wdata = cpu_wdata;
                    end else begin
                        mem_we    = ext_we;
                        mem_addr  = ext_addr;
                        mem_wdata = ext_wdata;
                    end
                    last_owner_d = pick_winner_s;
                    // Writes finish in the grant cycle; reads park the port until data returns
                    if (mem_we == 1'b0) begin
                        state_d    = RD_WAIT;
                        cnt_d      = CNT_INIT;
                        rd_owner_d = pick_winner_s;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = IDLE;
                    if (rd_owner_q == OWN_CPU) begin
                        cpu_rdata_d  = mem_rdata;
                        cpu_rvalid_d = 1'b1;
                    end else begin
                        ext_rdata_d  = mem_rdata;
                        ext_rvalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and return-path registers; Reset drops any in-flight read
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q      <= IDLE;
            cnt_q        <= CNT_ZERO;
            last_owner_q <= OWN_EXT;
            rd_owner_q   <= OWN_CPU;
            cpu_rvalid_q <= 1'b0;
            ext_rvalid_q <= 1'b0;
            cpu_rdata_q  <= {DATA_W{1'b0}};
            ext_rdata_q  <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
            rd_owner_q   <= rd_owner_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            ext_rvalid_q <= ext_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ext_rdata_q  <= ext_rdata_d;
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign ext_rvalid = ext_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign ext_rdata  = ext_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory between two requesters.
- The CPU port is driven by the multicycle control unit's MemRead/MemWrite with the MemSrc-selected address.
- The EXT port is used by the program loader and the I/O DMA.
- One access is in flight at a time, with round-robin arbitration and a fixed-latency read return path.
- While its request is pending without a grant, the CPU control FSM holds its current state.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory data width.
- RD_LAT, 1, memory read latency in cycles. Legal range 1..7.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- Reset  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU access request (MemRead|MemWrite).
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU access issued this cycle.
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata is new.
- cpu_rdata  out  DATA_W  last read data returned to CPU (held).
- ext_req, ext_we, ext_addr, ext_wdata  in  1/1/ADDR_W/DATA_W  same meaning as the CPU signals, for EXT.
- ext_gnt, ext_rvalid, ext_rdata  out  1/1/DATA_W  same meaning as the CPU signals, for EXT.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  valid exactly RD_LAT cycles after mem_en with mem_we=0.

Behaviour:
- Reset (Reset=0 at a clock edge):
  - state=IDLE, last_owner=EXT, so the CPU wins the first tie.
  - wait counter=0; cpu_rvalid=ext_rvalid=0; cpu_rdata=ext_rdata=0.
  - gnt, mem_en and mem_we are 0 while Reset=0.
  - mem_addr and mem_wdata are 0 when mem_en=0.
- States are IDLE and RD_WAIT.
- IDLE, combinational arbitration:
  - Only one requester asserts req: it wins.
  - Both assert req: the one that is not last_owner wins.
  - The winner's gnt=1 and mem_en=1, and mem_we/mem_addr/mem_wdata are copied from the winner's inputs in the same cycle.
  - last_owner is updated at the clock edge.
- Handshake:
  - A requester holds req/we/addr/wdata stable until it sees gnt=1.
  - A requester may drop req before grant; no access occurs.
  - gnt is high for exactly one cycle per access.
- Write: completes in the grant cycle, and the FSM stays in IDLE. Back-to-back writes are allowed, one per cycle, alternating owners under contention.
- Read:
  - The grant at cycle T moves the FSM to RD_WAIT with count=RD_LAT-1; the read owner is recorded.
  - In RD_WAIT, no grants are issued and mem_en=0; count decrements each cycle.
  - At the cycle where count=0 (T+RD_LAT), mem_rdata is captured into the owner's rdata register and the FSM returns to IDLE.
  - The owner's rvalid=1 at cycle T+RD_LAT+1. That cycle is IDLE, so a new grant may occur in it.
  - The non-owner's rdata is never modified.
- rvalid is a single-cycle pulse. rdata holds its value until the next read for the same owner.
- A request arriving during RD_WAIT waits; gnt stays 0 and no request is lost.
- Reset mid-read: the in-flight read is dropped, no rvalid follows, and the FSM is in IDLE at the next cycle.
- Both requesters idle: mem_en=0 and the state stays IDLE.
- Address/data widths pass through unchanged; there is no arithmetic on addresses.

Decomposition:
- Shared package (mem_arb_pkg):
  - state encodings IDLE=0 and RD_WAIT=1;
  - owner encodings OWN_CPU=0 and OWN_EXT=1;
  - default widths ADDR_W and DATA_W.
- One natural sub-module, rr_pick2:
  - 2-way round-robin picker;
  - inputs: req[1:0], last_owner;
  - outputs: grant one-hot and winner.
  - It is purely combinational and is reused by a future bus arbiter.

Test Plan:
1. CPU only, RD_LAT=1: cpu_req=1, cpu_we=0, cpu_addr=0x0010, memory[0x10]=0xBEEF at T → cpu_gnt=1 and mem_en=1 at T; cpu_rvalid=1 and cpu_rdata=0xBEEF at T+2; ext_rdata stays 0.
2. Tie after reset: both request writes, cpu to 0x0004/0x1111 and ext to 0x0008/0x2222 → T: cpu_gnt; T+1: ext_gnt; memory holds both values; no cycle has both gnt high.
3. Contention during read: CPU read is granted at T and ext_req rises at T+1 (RD_LAT=3) → ext_gnt=0 for T+1..T+3; cpu_rvalid at T+4; ext_gnt at T+4.
4. Alternation: both hold req for 6 write accesses → grants go CPU, EXT, CPU, EXT, CPU, EXT.
5. Reset mid-read: RD_LAT=3, CPU read granted at T, Reset=0 at T+1 → no cpu_rvalid in T+1..T+6; state IDLE; a CPU request after release is granted first in a tie.
6. Withdrawn request: ext_req pulses for 1 cycle during RD_WAIT and is low by IDLE → no ext_gnt, mem_en=0 in that IDLE cycle.
